// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared word width, NOP encoding and fetch state encoding.
package fetch_unit_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP = 16'h0000;
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read handshake between fetch_unit and its memory.
interface fetch_unit_if #(parameter int W = 16) ();
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_ready;
  logic [W-1:0] i_data;
  modport master (output i_req, output i_addr, input i_ready, input i_data);
  modport slave  (input i_req, input i_addr, output i_ready, output i_data);
endinterface

// File: rtl/fetch_unit_btb.sv
// fetch_btb: direct-mapped branch target buffer, full-tag compare.
// Lookup reads registered contents, so a same-cycle write to the same index returns the old entry.
module fetch_btb #(
  parameter int WORD_SIZE = 16,
  parameter int ENTRIES   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 hit,
  output logic [WORD_SIZE-1:0] target,
  input  logic                 wr,
  input  logic [WORD_SIZE-1:0] wr_pc,
  input  logic [WORD_SIZE-1:0] wr_target
);
  localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  logic [ENTRIES-1:0]   valid_q;
  logic [WORD_SIZE-1:0] tag_q [ENTRIES];
  logic [WORD_SIZE-1:0] tgt_q [ENTRIES];
  logic [IW-1:0]        rd_idx;
  logic [IW-1:0]        wr_idx;
  assign rd_idx = lookup_pc[IW-1:0];
  assign wr_idx = wr_pc[IW-1:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else if (wr) valid_q[wr_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      tag_q[wr_idx] <= wr_pc;
      tgt_q[wr_idx] <= wr_target;
    end
  end
  assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_pc);
  assign target = tgt_q[rd_idx];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch front end with stall/redirect/halt control.
// Optional BTB prediction enabled by defining FETCH_BTB_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE   = WORD_W,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
  parameter int                   BTB_ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic [WORD_SIZE-1:0] next_pc,
  input  logic                 halt,
  fetch_unit_if.master         imem,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] fetch_count,
  output logic                 is_halted,
  input  logic                 btb_wr,
  input  logic [WORD_SIZE-1:0] btb_wr_pc,
  input  logic [WORD_SIZE-1:0] btb_wr_target
);
  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] inst_q, inst_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] adv_pc;
`ifdef FETCH_BTB_EN
  logic                 btb_hit;
  logic [WORD_SIZE-1:0] btb_tgt;
  fetch_btb #(.WORD_SIZE(WORD_SIZE), .ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .reset_n   (reset_n),
    .lookup_pc (pc_q),
    .hit       (btb_hit),
    .target    (btb_tgt),
    .wr        (btb_wr),
    .wr_pc     (btb_wr_pc),
    .wr_target (btb_wr_target)
  );
  assign adv_pc = btb_hit ? btb_tgt : next_pc;
`else
  logic unused_btb;
  assign unused_btb = ^{btb_wr, btb_wr_pc, btb_wr_target, BTB_ENTRIES[0]};
  assign adv_pc = next_pc;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= WORD_SIZE'(NOP);
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  // Priority: redirect > halt > stall > normal fetch; HALTED only leaves through reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (redirect) begin
      state_d = ST_FETCH;
      pc_d    = redirect_pc;
      inst_d  = WORD_SIZE'(NOP);
      valid_d = 1'b0;
    end else if (halt) begin
      state_d = ST_HALTED;
      inst_d  = WORD_SIZE'(NOP);
      valid_d = 1'b0;
    end else if (stall) begin
      if (state_q == ST_FETCH && imem.i_ready) begin
        state_d = ST_HOLD;
        inst_d  = imem.i_data;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (state_q == ST_HOLD) begin
      state_d = ST_FETCH;
      pc_d    = adv_pc;
    end else begin
      pc_d    = imem.i_ready ? adv_pc : pc_q;
      inst_d  = imem.i_ready ? imem.i_data : WORD_SIZE'(NOP);
      valid_d = imem.i_ready;
      cnt_d   = imem.i_ready ? cnt_q + 1'b1 : cnt_q;
    end
  end
  assign imem.i_req  = (state_q == ST_FETCH);
  assign imem.i_addr = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign inst_valid  = valid_q;
  assign fetch_count = cnt_q;
  assign is_halted   = (state_q == ST_HALTED);
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of data_path.
- Owns the architectural PC and issues instruction reads to the instruction memory through a ready handshake.
- Captures the returned word and presents it, with a valid flag, for the IF/ID latch.
- Consumes data_path's nextPC, stall, redirect and halt indications.

Parameters:
WORD_SIZE, 16, width of PC, addresses and instruction words
RESET_PC, 16'h0000, PC value loaded on reset
BTB_ENTRIES, 4, number of branch-target-buffer entries (power of two; used only with FETCH_BTB_EN)

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
stall  input  1  hazard hold: freeze PC and buffered instruction
redirect  input  1  EX-resolved control-flow change or mispredict; squash the fetch
redirect_pc  input  WORD_SIZE  target PC when redirect=1
next_pc  input  WORD_SIZE  sequential or jump PC from data_path (nextPC)
halt  input  1  HLT decoded in ID
i_req  output  1  instruction read request (readM1)
i_addr  output  WORD_SIZE  fetch address (address1)
i_ready  input  1  memory presents a valid word on i_data this cycle
i_data  input  WORD_SIZE  instruction word (data1)
pc  output  WORD_SIZE  current PC (to data_path PC)
inst  output  WORD_SIZE  fetched instruction
inst_valid  output  1  inst holds a real instruction, not a bubble
fetch_count  output  WORD_SIZE  accepted-instruction counter
is_halted  output  1  fetch permanently stopped
btb_wr  input  1  BTB update strobe (FETCH_BTB_EN only)
btb_wr_pc  input  WORD_SIZE  PC of the resolved jump/branch (FETCH_BTB_EN only)
btb_wr_target  input  WORD_SIZE  its target (FETCH_BTB_EN only)

Behaviour:
- Reset (async, reset_n=0) sets: pc=RESET_PC, state=FETCH, inst=`NOP, inst_valid=0, fetch_count=0, is_halted=0. With FETCH_BTB_EN, all BTB valid bits are also cleared.
- Releasing reset mid-fetch drops any outstanding request. The first request after release is to RESET_PC.
- States:
  - FETCH: i_req=1, i_addr=pc.
  - HOLD: a word is buffered and stall=1; i_req=0.
  - HALTED: i_req=0.
- Per-posedge priority, highest first:
  1. redirect:
     - pc<=redirect_pc, inst<=`NOP, inst_valid<=0, state<=FETCH.
     - A word arriving in the same cycle (i_ready=1) is discarded and not counted.
     - redirect overrides stall and halt, and also exits HOLD.
  2. halt (state FETCH or HOLD):
     - state<=HALTED, is_halted<=1, inst<=`NOP, inst_valid<=0, pc holds.
     - HALTED is left only by reset. redirect is ignored once halted.
  3. stall:
     - pc, inst and inst_valid hold.
     - In FETCH with i_ready=1, the word is latched into inst, inst_valid<=1, fetch_count+1, and state goes to HOLD. pc is not advanced.
     - In HOLD with stall=0, state<=FETCH and pc<=next_pc.
  4. Normal, in FETCH:
     - i_ready=1: inst<=i_data, inst_valid<=1, fetch_count<=fetch_count+1 (wraps modulo 2^WORD_SIZE), pc<=next_pc.
     - i_ready=0: inst<=`NOP, inst_valid<=0, pc holds (memory-latency bubble).
- Latency: one cycle from i_ready to inst/inst_valid. Back-to-back fetches give one instruction per cycle when i_ready stays high.
- Handshake: i_addr must remain stable while i_req=1 and i_ready=0.
- pc wraps 16'hFFFF -> 16'h0000 with no flag.

Optional Feature:
FETCH_BTB_EN
- Defined:
  - Direct-mapped BTB of BTB_ENTRIES entries, indexed by pc low bits; each entry holds valid, full tag PC and target.
  - On an accepted fetch with a hit, pc<=target instead of next_pc.
  - btb_wr writes its entry at posedge. A simultaneous write and lookup to the same index returns the old contents.
  - redirect still wins.
- Undefined:
  - The btb_* ports exist but are ignored.
  - pc always advances to next_pc.

Decomposition:
- Shared constants in opcodes.v: `WORD_SIZE, `NOP, and fetch state encodings `FETCH_ST_FETCH=2'd0, `FETCH_ST_HOLD=2'd1, `FETCH_ST_HALTED=2'd2.
- One natural sub-module, fetch_btb: the BTB array with its lookup/update logic, instantiated only under FETCH_BTB_EN.

Test Plan:
1. Reset then i_ready tied 1, next_pc=pc+1, i_data=16'h6000+addr -> i_addr 0,1,2,3 on consecutive cycles; inst_valid=1 from cycle 2; fetch_count=3 after 3 accepts.
2. i_ready low 2 cycles for addr 5 -> i_addr stays 5, inst=`NOP, inst_valid=0; third cycle accepts the word, then pc=6.
3. stall=1 for 3 cycles while i_ready=1 at pc=8 -> inst frozen at mem[8], i_req=0 in HOLD, fetch_count +1 only; after release pc=next_pc=9.
4. redirect=1, redirect_pc=16'h0040, coinciding with i_ready=1 and stall=1 -> pc=16'h0040, inst=`NOP, inst_valid=0, count unchanged.
5. halt=1 at pc=16'h0010 -> is_halted=1 next cycle, i_req=0 thereafter, a subsequent redirect is ignored; async reset_n pulse mid-cycle -> pc=0, is_halted=0 immediately.
6. FETCH_BTB_EN: btb_wr pc=16'h0004 target=16'h0020, then fetch at 4 -> next pc=16'h0020 regardless of next_pc; without the macro -> pc=next_pc=5.
